// File: rtl/control_sequencer.sv
// Moore-style control sequencer: fetch over a ready-handshaked memory, decode IR[31:27],
// and step through the execute T-steps, driving every datapath and register-select strobe.
module control_sequencer #(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [4:0] ir_op,
   input  logic       con_ff,
   input  logic       mem_done,
   input  logic       stop,
   output logic       Gra,
   output logic       Grb,
   output logic       Grc,
   output logic       Rin,
   output logic       Rout,
   output logic       BAout,
   output logic       PCout,
   output logic       PCin,
   output logic       IncPC,
   output logic       IRin,
   output logic       MARin,
   output logic       MDRin,
   output logic       MDRout,
   output logic       Yin,
   output logic       Zin,
   output logic       Zlowout,
   output logic       Cout,
   output logic       CONin,
   output logic       Read,
   output logic       Write,
   output logic [3:0] alu_op,
   output logic       run,
   output logic       fault
);

   localparam logic [4:0] OpLd   = 5'b00000;
   localparam logic [4:0] OpLdi  = 5'b00001;
   localparam logic [4:0] OpSt   = 5'b00010;
   localparam logic [4:0] OpAdd  = 5'b00011;
   localparam logic [4:0] OpSub  = 5'b00100;
   localparam logic [4:0] OpAnd  = 5'b00101;
   localparam logic [4:0] OpOr   = 5'b00110;
   localparam logic [4:0] OpAddi = 5'b01100;
   localparam logic [4:0] OpAndi = 5'b01101;
   localparam logic [4:0] OpOri  = 5'b01110;
   localparam logic [4:0] OpBr   = 5'b10010;
   localparam logic [4:0] OpJr   = 5'b10011;
   localparam logic [4:0] OpNop  = 5'b11010;
   localparam logic [4:0] OpHalt = 5'b11011;

   localparam logic [7:0] TimeoutLast = 8'(MEM_TIMEOUT - 1);

   typedef enum logic [4:0] {
      StT0, StT1, StT2, StT3, StE1,
      StAlu2, StImm2, StWb, StMar,
      StLdRd, StLdWb, StStMdr, StStWr,
      StBr2, StBr3, StBr4, StHalt
   } state_e;

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       fault_q, fault_d;
   logic       in_wait;
   logic       done;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StT0;
         cnt_q   <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fault_q <= fault_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      fault_d = fault_q;
      done    = 1'b0;
      in_wait = (state_q == StT2) || (state_q == StLdRd) || (state_q == StStWr);
      case (state_q)
         StT0:    state_d = StT1;
         StT1:    state_d = StT2;
         StT2:    if (mem_done) state_d = StT3;
         StT3:    state_d = StE1;
         StE1: begin
            case (ir_op)
               OpAdd, OpSub, OpAnd, OpOr:                   state_d = StAlu2;
               OpAddi, OpAndi, OpOri, OpLdi, OpLd, OpSt:    state_d = StImm2;
               OpBr:                                        state_d = StBr2;
               OpJr, OpNop:                                 done    = 1'b1;
               OpHalt:                                      state_d = StHalt;
               default: begin
                  state_d = StHalt;
                  fault_d = 1'b1;
               end
            endcase
         end
         StAlu2:  state_d = StWb;
         StImm2:  state_d = (ir_op == OpLd || ir_op == OpSt) ? StMar : StWb;
         StWb:    done    = 1'b1;
         StMar:   state_d = (ir_op == OpLd) ? StLdRd : StStMdr;
         StLdRd:  if (mem_done) state_d = StLdWb;
         StLdWb:  done    = 1'b1;
         StStMdr: state_d = StStWr;
         StStWr:  if (mem_done) done = 1'b1;
         StBr2:   state_d = StBr3;
         StBr3:   state_d = StBr4;
         StBr4:   done    = 1'b1;
         StHalt:  state_d = StHalt;
         default: state_d = StHalt;
      endcase

      // A stalled wait step either times out into a faulted halt or keeps counting.
      if (in_wait && !mem_done) begin
         if (cnt_q == TimeoutLast) begin
            state_d = StHalt;
            fault_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end

      if (done) state_d = stop ? StHalt : StT0;
   end

   // Strobes decode from the state; the reset gate forces all outputs low while reset_n is low.
   always_comb begin
      {Gra, Grb, Grc, Rin, Rout, BAout} = '0;
      {PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout} = '0;
      {Yin, Zin, Zlowout, Cout, CONin, Read, Write} = '0;
      alu_op = 4'd0;
      run    = 1'b0;
      if (reset_n) begin
         run = (state_q != StHalt);
         case (state_q)
            StT0: {PCout, MARin, IncPC, Zin} = 4'b1111;
            StT1: {Zlowout, PCin} = 2'b11;
            StT2: {Read, MDRin} = 2'b11;
            StT3: {MDRout, IRin} = 2'b11;
            StE1: begin
               case (ir_op)
                  OpAdd, OpSub, OpAnd, OpOr, OpAddi, OpAndi, OpOri: {Grb, Rout, Yin} = 3'b111;
                  OpLdi, OpLd, OpSt: {Grb, BAout, Yin} = 3'b111;
                  OpBr: {Gra, Rout, CONin} = 3'b111;
                  OpJr: {Gra, Rout, PCin} = 3'b111;
                  default: ;
               endcase
            end
            StAlu2: begin
               {Grc, Rout, Zin} = 3'b111;
               case (ir_op)
                  OpSub:   alu_op = 4'd1;
                  OpAnd:   alu_op = 4'd2;
                  OpOr:    alu_op = 4'd3;
                  default: alu_op = 4'd0;
               endcase
            end
            StImm2: begin
               {Cout, Zin} = 2'b11;
               case (ir_op)
                  OpAndi:  alu_op = 4'd2;
                  OpOri:   alu_op = 4'd3;
                  default: alu_op = 4'd0;
               endcase
            end
            StWb:    {Zlowout, Gra, Rin} = 3'b111;
            StMar:   {Zlowout, MARin} = 2'b11;
            StLdRd:  {Read, MDRin} = 2'b11;
            StLdWb:  {MDRout, Gra, Rin} = 3'b111;
            StStMdr: {Gra, Rout, MDRin} = 3'b111;
            StStWr:  Write = 1'b1;
            StBr2:   {PCout, Yin} = 2'b11;
            StBr3:   {Cout, Zin} = 2'b11;
            StBr4:   {Zlowout, PCin} = {2{con_ff}};
            default: ;
         endcase
      end
   end

   assign fault = fault_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: fetch/execute strobe sequences, memory waits,
// timeout, illegal opcode, stop and asynchronous reset.
module tb_control_sequencer;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [4:0] ir_op;
   logic       con_ff, mem_done, stop;
   logic       Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, IRin;
   logic       MARin, MDRin, MDRout, Yin, Zin, Zlowout, Cout, CONin, Read, Write;
   logic [3:0] alu_op;
   logic       run, fault;

   int checks = 0;
   int failures = 0;

   // Strobe bit positions in the packed observation vector
   localparam logic [19:0] MGra = 20'd1 << 19, MGrb = 20'd1 << 18, MGrc = 20'd1 << 17;
   localparam logic [19:0] MRin = 20'd1 << 16, MRout = 20'd1 << 15, MBAout = 20'd1 << 14;
   localparam logic [19:0] MPCout = 20'd1 << 13, MPCin = 20'd1 << 12, MIncPC = 20'd1 << 11;
   localparam logic [19:0] MIRin = 20'd1 << 10, MMARin = 20'd1 << 9, MMDRin = 20'd1 << 8;
   localparam logic [19:0] MMDRout = 20'd1 << 7, MYin = 20'd1 << 6, MZin = 20'd1 << 5;
   localparam logic [19:0] MZlow = 20'd1 << 4, MCout = 20'd1 << 3, MCONin = 20'd1 << 2;
   localparam logic [19:0] MRead = 20'd1 << 1, MWrite = 20'd1 << 0;

   control_sequencer #(.MEM_TIMEOUT(8)) dut (
      .clk(clk), .reset_n(reset_n), .ir_op(ir_op), .con_ff(con_ff), .mem_done(mem_done),
      .stop(stop), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
      .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .IRin(IRin), .MARin(MARin), .MDRin(MDRin),
      .MDRout(MDRout), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Cout(Cout), .CONin(CONin),
      .Read(Read), .Write(Write), .alu_op(alu_op), .run(run), .fault(fault)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=no_finish expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [19:0] s, input logic [3:0] a,
                      input logic r, input logic f);
      logic [25:0] obs, expv;
      obs  = {Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, IRin, MARin, MDRin,
              MDRout, Yin, Zin, Zlowout, Cout, CONin, Read, Write, alu_op, run, fault};
      expv = {s, a, r, f};
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Starts sampled in T0; ends sampled in E1 with ir_op = op.
   task automatic fetch(input logic [4:0] op);
      chk("t0", MPCout | MMARin | MIncPC | MZin, 4'd0, 1'b1, 1'b0);
      tick();
      chk("t1", MZlow | MPCin, 4'd0, 1'b1, 1'b0);
      tick();
      chk("t2", MRead | MMDRin, 4'd0, 1'b1, 1'b0);
      ir_op = op;
      tick();
      chk("t3", MMDRout | MIRin, 4'd0, 1'b1, 1'b0);
      tick();
   endtask

   task automatic pulse_reset();
      reset_n = 1'b0;
      #1;
      chk("reset_async", 20'd0, 4'd0, 1'b0, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
   endtask

   initial begin
      reset_n  = 1'b0;
      ir_op    = 5'b0;
      con_ff   = 1'b0;
      mem_done = 1'b1;
      stop     = 1'b0;
      #2;
      chk("reset", 20'd0, 4'd0, 1'b0, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;

      // add: 7 cycles total
      fetch(5'b00011);
      chk("add_e1", MGrb | MRout | MYin, 4'd0, 1'b1, 1'b0);
      tick();
      chk("add_e2", MGrc | MRout | MZin, 4'd0, 1'b1, 1'b0);
      tick();
      chk("add_e3", MZlow | MGra | MRin, 4'd0, 1'b1, 1'b0);
      tick();

      // ldi
      fetch(5'b00001);
      chk("ldi_e1", MGrb | MBAout | MYin, 4'd0, 1'b1, 1'b0);
      tick();
      chk("ldi_e2", MCout | MZin, 4'd0, 1'b1, 1'b0);
      tick();
      chk("ldi_e3", MZlow | MGra | MRin, 4'd0, 1'b1, 1'b0);
      tick();

      // andi uses AND
      fetch(5'b01101);
      chk("andi_e1", MGrb | MRout | MYin, 4'd0, 1'b1, 1'b0);
      tick();
      chk("andi_e2", MCout | MZin, 4'd2, 1'b1, 1'b0);
      tick();
      chk("andi_e3", MZlow | MGra | MRin, 4'd0, 1'b1, 1'b0);
      tick();

      // ld with mem_done low for three edges in E4
      fetch(5'b00000);
      chk("ld_e1", MGrb | MBAout | MYin, 4'd0, 1'b1, 1'b0);
      tick();
      chk("ld_e2", MCout | MZin, 4'd0, 1'b1, 1'b0);
      tick();
      chk("ld_e3", MZlow | MMARin, 4'd0, 1'b1, 1'b0);
      mem_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("ld_e4_wait", MRead | MMDRin, 4'd0, 1'b1, 1'b0);
         if (i == 2) mem_done = 1'b0;
      end
      mem_done = 1'b1;
      tick();
      chk("ld_e5", MMDRout | MGra | MRin, 4'd0, 1'b1, 1'b0);
      tick();

      // br not taken, then taken
      for (int t = 0; t < 2; t++) begin
         con_ff = (t == 1);
         fetch(5'b10010);
         chk("br_e1", MGra | MRout | MCONin, 4'd0, 1'b1, 1'b0);
         tick();
         chk("br_e2", MPCout | MYin, 4'd0, 1'b1, 1'b0);
         tick();
         chk("br_e3", MCout | MZin, 4'd0, 1'b1, 1'b0);
         tick();
         chk(t == 1 ? "br_e4_taken" : "br_e4_not", (t == 1) ? (MZlow | MPCin) : 20'd0,
             4'd0, 1'b1, 1'b0);
         tick();
      end
      con_ff = 1'b0;

      // jr, then nop, then or
      fetch(5'b10011);
      chk("jr_e1", MGra | MRout | MPCin, 4'd0, 1'b1, 1'b0);
      tick();
      fetch(5'b11010);
      chk("nop_e1", 20'd0, 4'd0, 1'b1, 1'b0);
      tick();
      fetch(5'b00110);
      chk("or_e1", MGrb | MRout | MYin, 4'd0, 1'b1, 1'b0);
      tick();
      chk("or_e2", MGrc | MRout | MZin, 4'd3, 1'b1, 1'b0);
      tick();
      chk("or_e3", MZlow | MGra | MRin, 4'd0, 1'b1, 1'b0);
      tick();

      // sub with stop: completes then halts without fault
      fetch(5'b00100);
      chk("sub_e1", MGrb | MRout | MYin, 4'd0, 1'b1, 1'b0);
      stop = 1'b1;
      tick();
      chk("sub_e2", MGrc | MRout | MZin, 4'd1, 1'b1, 1'b0);
      tick();
      chk("sub_e3", MZlow | MGra | MRin, 4'd0, 1'b1, 1'b0);
      tick();
      chk("stop_halt", 20'd0, 4'd0, 1'b0, 1'b0);
      stop = 1'b0;
      tick();
      chk("halt_hold", 20'd0, 4'd0, 1'b0, 1'b0);
      pulse_reset();

      // illegal opcode
      fetch(5'b11111);
      chk("ill_e1", 20'd0, 4'd0, 1'b1, 1'b0);
      tick();
      chk("ill_halt", 20'd0, 4'd0, 1'b0, 1'b1);
      pulse_reset();

      // halt opcode
      fetch(5'b11011);
      chk("halt_e1", 20'd0, 4'd0, 1'b1, 1'b0);
      tick();
      chk("halt_op", 20'd0, 4'd0, 1'b0, 1'b0);
      pulse_reset();

      // fetch timeout: 8 wait cycles then faulted halt
      chk("to_t0", MPCout | MMARin | MIncPC | MZin, 4'd0, 1'b1, 1'b0);
      tick();
      chk("to_t1", MZlow | MPCin, 4'd0, 1'b1, 1'b0);
      mem_done = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("to_t2_wait", MRead | MMDRin, 4'd0, 1'b1, 1'b0);
      end
      tick();
      chk("to_halt", 20'd0, 4'd0, 1'b0, 1'b1);
      mem_done = 1'b1;
      tick();
      chk("to_sticky", 20'd0, 4'd0, 1'b0, 1'b1);
      pulse_reset();

      // st, with reset asserted mid-E5
      fetch(5'b00010);
      chk("st_e1", MGrb | MBAout | MYin, 4'd0, 1'b1, 1'b0);
      tick();
      chk("st_e2", MCout | MZin, 4'd0, 1'b1, 1'b0);
      tick();
      chk("st_e3", MZlow | MMARin, 4'd0, 1'b1, 1'b0);
      tick();
      chk("st_e4", MGra | MRout | MMDRin, 4'd0, 1'b1, 1'b0);
      mem_done = 1'b0;
      tick();
      chk("st_e5", MWrite, 4'd0, 1'b1, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      chk("st_rst_async", 20'd0, 4'd0, 1'b0, 1'b0);
      @(negedge clk);
      reset_n  = 1'b1;
      mem_done = 1'b1;
      #1;
      chk("post_rst_t0", MPCout | MMARin | MIncPC | MZin, 4'd0, 1'b1, 1'b0);
      tick();
      chk("post_rst_t1", MZlow | MPCin, 4'd0, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
